// File: rtl/psum_acc_relu.sv
// psum_acc_relu: accumulates groups of signed psums, then ReLU-clamps and saturates the sum
module psum_acc_relu #(
  parameter int psum_bw = 16,
  parameter int len_bw  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [psum_bw-1:0] in_psum,
  input  logic [len_bw-1:0]  acc_len,
  input  logic               relu_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [psum_bw-1:0] out_data
);
  localparam int acc_bw = psum_bw + len_bw;
  localparam logic signed [acc_bw-1:0] pos_max = {{(len_bw+1){1'b0}}, {(psum_bw-1){1'b1}}};
  localparam logic signed [acc_bw-1:0] neg_min = {{(len_bw+1){1'b1}}, {(psum_bw-1){1'b0}}};
  typedef enum logic {accum, hold} state_t;
  state_t state, state_nx;
  logic [len_bw-1:0] cnt, len, len_eff;
  logic relu, relu_eff, take, last;
  logic signed [acc_bw-1:0] acc, sum;
  logic [psum_bw-1:0] result;
  assign take = in_valid && in_ready;
  // group parameters come from the ports on the first psum, from the latched copies afterwards
  always_comb begin
    len_eff  = cnt == '0 ? (acc_len == '0 ? len_bw'(1) : acc_len) : len;
    relu_eff = cnt == '0 ? relu_en : relu;
    sum      = (cnt == '0 ? '0 : acc) + {{len_bw{in_psum[psum_bw-1]}}, in_psum};
    last     = cnt + len_bw'(1) == len_eff;
    result   = relu_eff && sum[acc_bw-1] ? '0 :
               sum > pos_max ? pos_max[psum_bw-1:0] :
               sum < neg_min ? neg_min[psum_bw-1:0] : sum[psum_bw-1:0];
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= accum;
    else state <= state_nx;
  end
  // next state: leave ACCUM on the closing psum, leave HOLD when the result is taken
  always_comb begin
    state_nx = state == accum ? (take && last ? hold : accum) : (out_ready ? accum : hold);
  end
  // handshake outputs decoded from the registered state
  always_comb begin
    in_ready  = state == accum;
    out_valid = state == hold;
  end
  // accumulator, group counter, latched group settings and the held result
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      len      <= '0;
      relu     <= 1'b0;
      acc      <= '0;
      out_data <= '0;
    end else if (take) begin
      acc <= sum;
      cnt <= last ? '0 : cnt + len_bw'(1);
      if (cnt == '0) begin
        len  <= len_eff;
        relu <= relu_en;
      end
      if (last) out_data <= result;
    end
  end
endmodule

// File: tb/tb_psum_acc_relu.sv
// tb_psum_acc_relu: directed and randomized checks of psum_acc_relu against a plain-arithmetic model
module tb_psum_acc_relu;
  logic clk = 0, reset = 1, in_valid = 0, relu_en = 0, out_ready = 0;
  logic [15:0] in_psum = 0;
  logic [3:0] acc_len = 0;
  logic in_ready, out_valid;
  logic [15:0] out_data;
  int n_cmp = 0, n_err = 0;

  psum_acc_relu #(.psum_bw(16), .len_bw(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_psum(in_psum),
    .acc_len(acc_len), .relu_en(relu_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_result(input longint s, input bit r);
    if (r && s < 0) return 16'h0000;
    if (s > 32767) return 16'h7fff;
    if (s < -32768) return 16'h8000;
    return 16'(s);
  endfunction

  task automatic push(input logic [15:0] p, input logic [3:0] l, input logic r);
    in_valid = 1; in_psum = p; acc_len = l; relu_en = r;
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic consume();
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  task automatic test_reset();
    reset = 1; in_valid = 1; in_psum = 16'h1234;
    repeat (2) @(negedge clk);
    reset = 0; in_valid = 0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_cmp++; if (out_data !== 16'h0000) begin n_err++; $display("FAIL reset_out_data got %h exp 0000", out_data); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_basic();
    push(16'd5, 4'd3, 0);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid got %b exp 0", out_valid); end
    push(-16'sd2, 4'd3, 0);
    push(16'd10, 4'd3, 0);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got %b exp 1", out_valid); end
    n_cmp++; if (out_data !== 16'd13) begin n_err++; $display("FAIL basic_data got %h exp %h", out_data, 16'd13); end
    consume();
  endtask

  task automatic test_relu();
    push(-16'sd7, 4'd2, 1); push(16'd3, 4'd2, 1);
    n_cmp++; if (out_data !== 16'h0000) begin n_err++; $display("FAIL relu_on got %h exp 0000", out_data); end
    consume();
    push(-16'sd7, 4'd2, 0); push(16'd3, 4'd2, 0);
    n_cmp++; if (out_data !== 16'hfffc) begin n_err++; $display("FAIL relu_off got %h exp fffc", out_data); end
    consume();
  endtask

  task automatic test_sat();
    push(16'h7fff, 4'd2, 0); push(16'd1, 4'd2, 0);
    n_cmp++; if (out_data !== 16'h7fff) begin n_err++; $display("FAIL sat_pos got %h exp 7fff", out_data); end
    consume();
    push(16'h8000, 4'd2, 0); push(16'hffff, 4'd2, 0);
    n_cmp++; if (out_data !== 16'h8000) begin n_err++; $display("FAIL sat_neg got %h exp 8000", out_data); end
    consume();
  endtask

  task automatic test_hold();
    push(16'd100, 4'd1, 0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_psum = 16'($urandom);
      @(negedge clk);
      n_cmp++; if (out_data !== 16'd100 || out_valid !== 1'b1) begin n_err++; $display("FAIL hold_stable cyc %0d got %h/%b exp 0064/1", i, out_data, out_valid); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL hold_in_ready cyc %0d got %b exp 0", i, in_ready); end
    end
    in_valid = 0;
    consume();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL hold_release_valid got %b exp 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL hold_release_ready got %b exp 1", in_ready); end
    push(16'd7, 4'd1, 0);
    n_cmp++; if (out_data !== 16'd7) begin n_err++; $display("FAIL hold_after got %h exp 0007", out_data); end
    consume();
  endtask

  task automatic test_gaps();
    for (int i = 1; i <= 3; i++) begin
      push(16'(i), 4'd3, 0);
      if (i < 3) begin
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL gaps_early got %b exp 0", out_valid); end
      end
    end
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 16'd6) begin n_err++; $display("FAIL gaps_data got %h/%b exp 0006/1", out_data, out_valid); end
    consume();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL gaps_single got %b exp 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    push(16'd50, 4'd4, 0); push(16'd60, 4'd4, 0);
    reset = 1; @(negedge clk); reset = 0;
    for (int i = 0; i < 4; i++) push(16'd4, 4'd4, 0);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 16'd16) begin n_err++; $display("FAIL reset_mid got %h/%b exp 0010/1", out_data, out_valid); end
    reset = 1; @(negedge clk); reset = 0;
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 16'h0000) begin n_err++; $display("FAIL reset_hold got %h/%b exp 0000/0", out_data, out_valid); end
    push(16'd9, 4'd0, 0);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 16'd9) begin n_err++; $display("FAIL len_zero got %h/%b exp 0009/1", out_data, out_valid); end
    consume();
  endtask

  task automatic test_random();
    logic [3:0] l;
    logic r;
    logic [15:0] p, exp;
    longint s;
    int n;
    for (int g = 0; g < 60; g++) begin
      l = 4'($urandom_range(0, 15)); r = 1'($urandom); n = l == 0 ? 1 : int'(l); s = 0;
      for (int i = 0; i < n; i++) begin
        p = $urandom_range(0, 3) == 0 ? ($urandom_range(0, 1) ? 16'h7fff : 16'h8000) : 16'($urandom);
        s += longint'($signed(p));
        push(p, i == 0 ? l : 4'($urandom), i == 0 ? r : 1'($urandom));
        if (i < n - 1) repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rand_early grp %0d got %b exp 0", g, out_valid); end
        end
      end
      exp = ref_result(s, r);
      n_cmp++; if (out_valid !== 1'b1 || out_data !== exp) begin n_err++; $display("FAIL rand_data grp %0d got %h/%b exp %h/1", g, out_data, out_valid, exp); end
      repeat ($urandom_range(0, 3)) begin
        in_valid = 1'($urandom); in_psum = 16'($urandom);
        @(negedge clk);
        n_cmp++; if (out_data !== exp || in_ready !== 1'b0) begin n_err++; $display("FAIL rand_hold grp %0d got %h/%b exp %h/0", g, out_data, in_ready, exp); end
      end
      in_valid = 0;
      consume();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rand_release grp %0d got %b exp 0", g, out_valid); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_relu();
    test_sat();
    test_hold();
    test_gaps();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
